// File: rtl/l2_mem_ctrl_pkg.sv
// ============================================================================
//  Module   : l2_mem_ctrl_pkg
//  Purpose  : Shared widths and FSM encodings for the L2 memory controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_mem_ctrl_pkg;

    localparam int DEF_TAG_W   = 18;
    localparam int DEF_INDEX_W = 8;
    localparam int DEF_LINE_W  = 512;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WRITE = 2'd1;
    localparam state_t ST_READ  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/l2_mem_ctrl_mem_line_array.sv
// ============================================================================
//  Module   : mem_line_array
//  Purpose  : Line store with synchronous write and combinational read;
//             contents are never reset, so a vendor RAM can replace it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_line_array #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LINE_W     = 512
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] wr_addr_i,
    input  logic [LINE_W-1:0]     wr_data_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [LINE_W-1:0]     rd_data_o
);

    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/l2_mem_ctrl.sv
// ============================================================================
//  Module   : l2_mem_ctrl
//  Purpose  : Main-memory endpoint for L2 fills and writebacks with counted
//             DRAM latency. Optional macro MEM_STATS_EN adds rd_count/wr_count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_ctrl
    import l2_mem_ctrl_pkg::*;
#(
    parameter int TAG_W      = DEF_TAG_W,
    parameter int INDEX_W    = DEF_INDEX_W,
    parameter int LINE_W     = DEF_LINE_W,
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LATENCY = 8,
    parameter int WR_LATENCY = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               read_L2_MEM,
    input  logic               write_L2_MEM,
    input  logic [INDEX_W-1:0] index_L2_MEM,
    input  logic [TAG_W-1:0]   tag_L2_MEM,
    input  logic [TAG_W-1:0]   write_tag_L2_MEM,
    input  logic [LINE_W-1:0]  write_data_L2_MEM,
    output logic [LINE_W-1:0]  read_data_MEM_L2,
    output logic               ready_MEM_L2
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    rd_pend_q;
    logic [LINE_W-1:0]       rdata_q;
    logic [DEPTH_LOG2-1:0]   rd_addr_q, wr_addr_q;
    logic [LINE_W-1:0]       wr_data_q;

    logic                    w_cnt_zero;
    logic                    w_accept_wr, w_accept_rd;
    logic                    w_mem_we, w_rd_fire;
    logic [DEPTH_LOG2-1:0]   w_req_rd_addr, w_req_wr_addr;
    logic [LINE_W-1:0]       w_mem_rd_data;

    // Address bits above DEPTH_LOG2 alias onto the same physical line.
    assign w_req_rd_addr = DEPTH_LOG2'({tag_L2_MEM, index_L2_MEM});
    assign w_req_wr_addr = DEPTH_LOG2'({write_tag_L2_MEM, index_L2_MEM});
    assign w_cnt_zero    = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            if (w_accept_wr) begin
                rd_pend_q <= read_L2_MEM;
            end else if (w_accept_rd) begin
                rd_pend_q <= 1'b0;
            end
            if (w_rd_fire) begin
                rdata_q <= w_mem_rd_data;
            end
        end
    end

    // Request capture needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (w_accept_wr) begin
            wr_addr_q <= w_req_wr_addr;
            wr_data_q <= write_data_L2_MEM;
            rd_addr_q <= w_req_rd_addr;
        end else if (w_accept_rd) begin
            rd_addr_q <= w_req_rd_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (write_L2_MEM) begin
                    state_d = ST_WRITE;
                    cnt_d   = WR_LOAD;
                end else if (read_L2_MEM) begin
                    state_d = ST_READ;
                    cnt_d   = RD_LOAD;
                end
            end
            ST_WRITE: begin
                if (w_cnt_zero) begin
                    if (rd_pend_q) begin
                        state_d = ST_READ;
                        cnt_d   = RD_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READ: begin
                if (w_cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_accept_wr = (state_q == ST_IDLE) && write_L2_MEM;
        w_accept_rd = (state_q == ST_IDLE) && !write_L2_MEM && read_L2_MEM;
        w_mem_we    = (state_q == ST_WRITE) && w_cnt_zero;
        w_rd_fire   = (state_q == ST_READ) && w_cnt_zero;
        // A combined request signals completion only after its read phase.
        ready_d     = (w_mem_we && !rd_pend_q) || w_rd_fire;
    end

    mem_line_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LINE_W     (LINE_W)
    ) u_array (
        .clk       (clk),
        .we_i      (w_mem_we),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (wr_data_q),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (w_mem_rd_data)
    );

    assign read_data_MEM_L2 = rdata_q;
    assign ready_MEM_L2     = ready_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (w_rd_fire) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (w_mem_we) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_ctrl.sv
// ============================================================================
//  Module   : tb_l2_mem_ctrl
//  Purpose  : Scoreboard bench for l2_mem_ctrl (latency, data, reset abort).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_ctrl;

    localparam int RD_LAT = 8;
    localparam int WR_LAT = 8;

    logic         clk = 1'b0;
    logic         nrst;
    logic         read_L2_MEM, write_L2_MEM;
    logic [7:0]   index_L2_MEM;
    logic [17:0]  tag_L2_MEM, write_tag_L2_MEM;
    logic [511:0] write_data_L2_MEM;
    logic [511:0] read_data_MEM_L2;
    logic         ready_MEM_L2;
`ifdef MEM_STATS_EN
    logic [31:0]  rd_count, wr_count;
`endif

    always #5 clk = ~clk;

    l2_mem_ctrl dut (
        .clk               (clk),
        .nrst              (nrst),
        .read_L2_MEM       (read_L2_MEM),
        .write_L2_MEM      (write_L2_MEM),
        .index_L2_MEM      (index_L2_MEM),
        .tag_L2_MEM        (tag_L2_MEM),
        .write_tag_L2_MEM  (write_tag_L2_MEM),
        .write_data_L2_MEM (write_data_L2_MEM),
        .read_data_MEM_L2  (read_data_MEM_L2),
        .ready_MEM_L2      (ready_MEM_L2)
`ifdef MEM_STATS_EN
        ,
        .rd_count          (rd_count),
        .wr_count          (wr_count)
`endif
    );

    typedef struct {
        int           exp_cyc;
        logic [511:0] data;
        bit           chk;
    } exp_t;

    exp_t         sb[$];
    logic [511:0] mdl [int];
    logic [511:0] lr_val;
    bit           lr_known;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every ready pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ready_MEM_L2 === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.exp_cyc) begin
                    n_fail++;
                    $display("FAIL ready_latency: ready at cycle %0d, required cycle %0d", cyc, e.exp_cyc);
                end
                if (e.chk) begin
                    n_cmp++;
                    if (read_data_MEM_L2 !== e.data) begin
                        n_fail++;
                        $display("FAIL read_data: got %h, required %h", read_data_MEM_L2[63:0], e.data[63:0]);
                    end
                end
            end
        end
    end

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Drive one request, hold it until the scoreboard drains, then drop it.
    task automatic issue(input bit wr, input bit rd, input logic [17:0] wtag,
                         input logic [17:0] rtag, input logic [7:0] idx,
                         input logic [511:0] wdata, input bit wait_first,
                         input bit scramble);
        exp_t e;
        int   lat, a_w, a_r;
        if (wait_first) begin
            @(negedge clk);
            #1;
        end
        lat = (wr ? WR_LAT : 0) + (rd ? RD_LAT : 0);
        a_w = int'({wtag, idx}) & 1023;
        a_r = int'({rtag, idx}) & 1023;
        if (wr) mdl[a_w] = wdata;
        if (rd) begin
            lr_known = mdl.exists(a_r);
            lr_val   = lr_known ? mdl[a_r] : '0;
        end
        e.chk     = lr_known;
        e.data    = lr_val;
        e.exp_cyc = cyc + 1 + lat;
        sb.push_back(e);
        write_L2_MEM      = wr;
        read_L2_MEM       = rd;
        write_tag_L2_MEM  = wtag;
        tag_L2_MEM        = rtag;
        index_L2_MEM      = idx;
        write_data_L2_MEM = wdata;
        for (int i = 0; i < lat + 20; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
            if (scramble && i == 1) begin
                tag_L2_MEM        = 18'($urandom);
                write_tag_L2_MEM  = 18'($urandom);
                index_L2_MEM      = 8'($urandom);
                write_data_L2_MEM = rand_line();
            end
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: pending=%0d at cycle %0d, required 0", sb.size(), cyc);
            sb.delete();
        end
        write_L2_MEM = 1'b0;
        read_L2_MEM  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        nrst     = 1'b1;
        lr_known = 1'b1;
        lr_val   = '0;
    endtask

    task automatic test_reset();
        nrst              = 1'b0;
        read_L2_MEM       = 1'b0;
        write_L2_MEM      = 1'b0;
        index_L2_MEM      = '0;
        tag_L2_MEM        = '0;
        write_tag_L2_MEM  = '0;
        write_data_L2_MEM = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ready_MEM_L2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0", ready_MEM_L2);
        end
        n_cmp++;
        if (read_data_MEM_L2 !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 0", read_data_MEM_L2[63:0]);
        end
        // Request raised in the same cycle reset is released.
        nrst     = 1'b1;
        lr_known = 1'b1;
        lr_val   = '0;
        issue(1'b0, 1'b1, '0, 18'h00001, 8'h02, '0, 1'b0, 1'b0);
    endtask

    task automatic test_write_then_read();
        logic [511:0] d;
        d = {16{32'hDEADBEEF}};
        issue(1'b1, 1'b0, 18'h00001, '0, 8'h02, d, 1'b1, 1'b0);
        issue(1'b0, 1'b1, '0, 18'h00001, 8'h02, '0, 1'b1, 1'b0);
    endtask

    task automatic test_write_read_same();
        logic [511:0] d;
        d = 512'h1234;
        issue(1'b1, 1'b1, 18'h00003, 18'h00003, 8'h10, d, 1'b1, 1'b0);
    endtask

    task automatic test_write_read_diff();
        logic [511:0] a, b;
        a = rand_line();
        b = rand_line();
        issue(1'b1, 1'b0, 18'h00001, '0, 8'h05, b, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 18'h00000, 18'h00001, 8'h05, a, 1'b1, 1'b0);
        issue(1'b0, 1'b1, '0, 18'h00000, 8'h05, '0, 1'b1, 1'b0);
    endtask

    task automatic test_aliasing();
        issue(1'b1, 1'b0, 18'h00004, '0, 8'h20, rand_line(), 1'b1, 1'b0);
        issue(1'b0, 1'b1, '0, 18'h00000, 8'h20, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [511:0] old_d;
        old_d = rand_line();
        issue(1'b1, 1'b0, '0, '0, 8'h07, old_d, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        write_tag_L2_MEM  = '0;
        index_L2_MEM      = 8'h07;
        write_data_L2_MEM = ~old_d;
        write_L2_MEM      = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        nrst         = 1'b0;
        write_L2_MEM = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready_MEM_L2 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ready: got %b, required 0", ready_MEM_L2);
        end
        n_cmp++;
        if (read_data_MEM_L2 !== '0) begin
            n_fail++;
            $display("FAIL abort_rdata: got %h, required 0", read_data_MEM_L2[63:0]);
        end
        #1;
        nrst     = 1'b1;
        lr_known = 1'b1;
        lr_val   = '0;
        repeat (3) @(negedge clk);
        issue(1'b0, 1'b1, '0, '0, 8'h07, '0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [7:0]  idx;
            logic [17:0] t;
            int          op;
            idx = 8'h40 + 8'($urandom_range(0, 3));
            t   = 18'($urandom_range(0, 1));
            op  = (i < 2) ? 1 : $urandom_range(0, 2);
            issue(op != 0, op != 1, t, t, idx, rand_line(), 1'b1, (i % 3) == 2);
        end
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) issue(1'b0, 1'b1, '0, '0, 8'h05, '0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) issue(1'b1, 1'b0, '0, '0, 8'h50, rand_line(), 1'b1, 1'b0);
        issue(1'b1, 1'b1, '0, '0, 8'h51, rand_line(), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rd_count !== 32'd4) begin
            n_fail++;
            $display("FAIL rd_count: got %0d, required 4", rd_count);
        end
        n_cmp++;
        if (wr_count !== 32'd3) begin
            n_fail++;
            $display("FAIL wr_count: got %0d, required 3", wr_count);
        end
        do_reset();
        @(negedge clk);
        n_cmp++;
        if (rd_count !== 32'd0 || wr_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_reset: got %0d/%0d, required 0/0", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_then_read();
        test_write_read_same();
        test_write_read_diff();
        test_aliasing();
        test_reset_abort();
        test_back_to_back();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
